// File: rtl/cr_apb_bridge_pkg.sv
// Shared types and constants for the AHB-lite to APB3 bridge.
// slv_idx() extracts the APB slave index field from an address.
package cr_apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } bridge_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // lsb is the SLV_ADDR_LSB of the instance; sw is the index field width (<= 4)
  function automatic logic [3:0] slv_idx(input logic [63:0] addr,
                                         input int unsigned lsb,
                                         input int unsigned sw);
    return 4'((addr >> lsb) & ((64'd1 << sw) - 64'd1));
  endfunction

endpackage

// File: rtl/cr_apb_slv_decode.sv
// Slave index to one-hot APB select, flagging indices with no slave behind them.
module cr_apb_slv_decode #(
  parameter int NUM_SLV = 4
) (
  input  logic [3:0]         idx,
  output logic [NUM_SLV-1:0] sel,
  output logic               decode_err
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel[i] = (idx == 4'(i));
    end
    decode_err = ({28'd0, idx} >= 32'(NUM_SLV));
  end

endmodule

// File: rtl/cr_ahb2apb_bridge.sv
// AHB-lite slave to APB3 master bridge with NUM_SLV decoded slaves.
// Define CR_APB_TIMEOUT_EN to add the ACCESS watchdog and the timeout_flag port.
module cr_ahb2apb_bridge
  import cr_apb_bridge_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int NUM_SLV      = 4,
  parameter int SLV_ADDR_LSB = 12,
  parameter int TIMEOUT_CYC  = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hsel,
  input  logic [ADDR_W-1:0]         haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [DATA_W-1:0]         hwdata,
  input  logic                      hready_in,
  output logic                      hreadyout,
  output logic                      hresp,
  output logic [DATA_W-1:0]         hrdata,
`ifdef CR_APB_TIMEOUT_EN
  output logic                      timeout_flag,
`endif
  output logic [ADDR_W-1:0]         paddr,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  bridge_state_e       state;
  logic [3:0]          idx_live, idx_q;
  logic [NUM_SLV-1:0]  sel_live;
  logic                decode_err, xfer_req, accept;
  logic [DATA_W-1:0]   rdata_mux;
  logic                ready_mux, err_mux;
  logic                unused_hsize;

  // APB transfers are always full width, so the AHB size is not needed
  assign unused_hsize = ^hsize;

  always_comb begin
    xfer_req = 1'b0;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: xfer_req = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  xfer_req = 1'b0;
    endcase
  end

  assign accept   = hsel & xfer_req & hready_in;
  assign idx_live = slv_idx(64'(haddr), SLV_ADDR_LSB, SW);

  cr_apb_slv_decode #(.NUM_SLV(NUM_SLV)) u_decode (
    .idx        (idx_live),
    .sel        (sel_live),
    .decode_err (decode_err)
  );

  always_comb begin
    rdata_mux = '0;
    ready_mux = 1'b0;
    err_mux   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == 4'(i)) begin
        rdata_mux = prdata[i*DATA_W +: DATA_W];
        ready_mux = pready[i];
        err_mux   = pslverr[i];
      end
    end
  end

`ifdef CR_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx_q     <= '0;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      hrdata    <= '0;
      paddr     <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
`ifdef CR_APB_TIMEOUT_EN
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          state     <= ST_IDLE;
          psel      <= '0;
          penable   <= 1'b0;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
          if (accept) begin
            paddr     <= haddr;
            pwrite    <= hwrite;
            idx_q     <= idx_live;
            hreadyout <= 1'b0;
`ifdef CR_APB_TIMEOUT_EN
            timeout_flag <= 1'b0;
`endif
            if (decode_err) begin
              state <= ST_ERR1;
              hresp <= HRESP_ERROR;
            end else begin
              state <= ST_SETUP;
              psel  <= sel_live;
            end
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          penable <= 1'b1;
          pwdata  <= hwdata;
`ifdef CR_APB_TIMEOUT_EN
          to_cnt  <= CNT_W'(TIMEOUT_CYC - 1);
`endif
        end
        ST_ACCESS: begin
          if (ready_mux) begin
            psel    <= '0;
            penable <= 1'b0;
            if (err_mux) begin
              state <= ST_ERR1;
              hresp <= HRESP_ERROR;
            end else begin
              state     <= ST_DONE;
              hreadyout <= 1'b1;
              if (!pwrite) hrdata <= rdata_mux;
            end
          end else begin
`ifdef CR_APB_TIMEOUT_EN
            // watchdog: abandon the slave after TIMEOUT_CYC ACCESS cycles
            if (to_cnt == '0) begin
              psel         <= '0;
              penable      <= 1'b0;
              state        <= ST_ERR1;
              hresp        <= HRESP_ERROR;
              timeout_flag <= 1'b1;
            end else begin
              to_cnt <= to_cnt - CNT_W'(1);
            end
`endif
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
          hresp     <= HRESP_ERROR;
        end
        ST_ERR2: begin
          state     <= ST_IDLE;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
